multicycle_ctrl_fsm: RTL and testbench

Multicycle sequencer for the RV32 base-subset datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives a req/ready handshake to the shared instruction/data memory port and issues per-state datapath strobes. It replaces single-cycle opcode decode with a state machine, adding wait-state handling, memory timeout, illegal-opcode halt and a retired-instruction counter.

---
 rtl/multicycle_ctrl_fsm.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer for the RV32 base-subset datapath: fetch/decode/execute/memory/writeback
// with a memory req/ready handshake, memory timeout, illegal-opcode halt and a retired-instruction counter.
module multicycle_ctrl_fsm #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             mem_req,
  output logic             mem_addr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_BR    = 7'd99;

  // wait_cnt never exceeds MEM_TIMEOUT-1 before the timeout fires
  localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [6:0]        r_op_q;
  logic              r_illegal;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_retired;

  logic [2:0] w_next;
  logic       w_wait_inc;
  logic       w_retire;
  logic       w_set_illegal;
  logic       w_set_timeout;
  logic       w_unused_instr;

  assign w_unused_instr = ^instruction[31:7];

  assign state   = r_state;
  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign retired = r_retired;

  always_comb begin
    mem_req       = 1'b0;
    mem_addr_src  = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_op        = 2'd0;
    alu_src       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    w_next        = r_state;
    w_wait_inc    = 1'b0;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next        = S_HALT;
          w_set_timeout = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_DECODE: begin
        if (instruction[6:0] == OP_R || instruction[6:0] == OP_LOAD ||
            instruction[6:0] == OP_STORE || instruction[6:0] == OP_BR) begin
          w_next = S_EXEC;
        end else begin
          w_next        = S_HALT;
          w_set_illegal = 1'b1;
        end
      end

      S_EXEC: begin
        case (r_op_q)
          OP_R: begin
            alu_op = 2'd2;
            w_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_op  = 2'd0;
            alu_src = 1'b1;
            w_next  = S_MEM;
          end
          OP_BR: begin
            alu_op   = 2'd1;
            pc_write = zero;
            pc_src   = 1'b1;
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
          default: w_next = S_HALT;
        endcase
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        alu_src      = 1'b1;
        mem_read     = (r_op_q == OP_LOAD);
        mem_write    = (r_op_q == OP_STORE);
        if (mem_ready) begin
          if (r_op_q == OP_LOAD) begin
            w_next = S_WB;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next        = S_HALT;
          w_set_timeout = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_op_q == OP_LOAD);
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end

      S_HALT: w_next = S_HALT;

      // unused codes fall into HALT
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_op_q     <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (r_state == S_DECODE) begin
        r_op_q <= instruction[6:0];
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: an instruction-level model expands each instruction
// and its memory wait pattern into the expected per-cycle state and strobes.
module tb_multicycle_ctrl_fsm;

  localparam int MT = 8;
  localparam int CW = 4;
  localparam bit O  = 1'b0;
  localparam bit I  = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instruction;
  logic          mem_ready;
  logic          zero;
  logic          mem_req, mem_addr_src, mem_read, mem_write, ir_write, pc_write, pc_src;
  logic [1:0]    alu_op;
  logic          alu_src, reg_write, mem_to_reg, illegal, timeout;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_ctrl_fsm #(.CNT_W(CW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_addr_src(mem_addr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal), .timeout(timeout),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int         m_ret;
  bit         m_ill, m_to, m_halt;
  bit         exp_valid = 1'b0;
  logic [2:0]  e_state;
  logic [11:0] e_strb;
  logic [11:0] dut_strb;

  assign dut_strb = {mem_req, mem_addr_src, mem_read, mem_write, ir_write, pc_write, pc_src,
                     alu_op, alu_src, reg_write, mem_to_reg};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [11:0] sb(input bit req, input bit asrc, input bit rd, input bit wr,
                                     input bit irw, input bit pcw, input bit pcs,
                                     input logic [1:0] aop, input bit alus, input bit rw,
                                     input bit m2r);
    return {req, asrc, rd, wr, irw, pcw, pcs, aop, alus, rw, m2r};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("state", 32'(state), 32'(e_state));
      chk("strobes", 32'(dut_strb), 32'(e_strb));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("retired", 32'(retired), m_ret);
    end
  end

  // One clock of stimulus with its expected outputs; returns just after the next rising edge.
  task automatic step(input logic [2:0] st, input logic [11:0] s, input bit rdy, input bit z);
    mem_ready = rdy;
    zero      = z;
    e_state   = st;
    e_strb    = s;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    m_ret = (m_ret + 1) % (1 << CW);
  endtask

  // wf/wm: cycles of mem_ready=0 before the fetch / memory access completes (>= MT times out)
  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input bit z,
                           output int cyc);
    logic [6:0] op;
    bit is_ld, is_st;
    op    = ins[6:0];
    is_ld = (op == 7'd3);
    is_st = (op == 7'd35);
    cyc   = 0;
    instruction = ins;
    for (int i = 0; i < wf && i < MT; i++) begin
      step(3'd0, sb(I,O,I,O,O,O,O,2'd0,O,O,O), 1'b0, rb()); cyc++;
    end
    if (wf >= MT) begin m_to = 1'b1; m_halt = 1'b1; return; end
    step(3'd0, sb(I,O,I,O,I,I,O,2'd0,O,O,O), 1'b1, rb()); cyc++;
    step(3'd1, 12'd0, rb(), rb()); cyc++;
    if (!(op inside {7'd51, 7'd3, 7'd35, 7'd99})) begin m_ill = 1'b1; m_halt = 1'b1; return; end
    if (op == 7'd99) begin
      step(3'd2, sb(O,O,O,O,O,z,I,2'd1,O,O,O), rb(), z); cyc++;
      retire();
      return;
    end
    if (op == 7'd51) begin
      step(3'd2, sb(O,O,O,O,O,O,O,2'd2,O,O,O), rb(), rb()); cyc++;
      step(3'd4, sb(O,O,O,O,O,O,O,2'd0,O,I,O), rb(), rb()); cyc++;
      retire();
      return;
    end
    step(3'd2, sb(O,O,O,O,O,O,O,2'd0,I,O,O), rb(), rb()); cyc++;
    for (int i = 0; i < wm && i < MT; i++) begin
      step(3'd3, sb(I,I,is_ld,is_st,O,O,O,2'd0,I,O,O), 1'b0, rb()); cyc++;
    end
    if (wm >= MT) begin m_to = 1'b1; m_halt = 1'b1; return; end
    step(3'd3, sb(I,I,is_ld,is_st,O,O,O,2'd0,I,O,O), 1'b1, rb()); cyc++;
    if (is_st) begin retire(); return; end
    step(3'd4, sb(O,O,O,O,O,O,O,2'd0,O,I,I), rb(), rb()); cyc++;
    retire();
  endtask

  task automatic run_halt(input int n, input bit force_ready);
    for (int i = 0; i < n; i++) step(3'd5, 12'd0, force_ready | rb(), rb());
  endtask

  // Asynchronous reset asserted between clock edges; outputs must react before any edge.
  task automatic do_reset();
    exp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd1);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_ret  = 0;
    m_ill  = 1'b0;
    m_to   = 1'b0;
    m_halt = 1'b0;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [6:0] ops [4];
    logic [31:0] r;
    ops[0] = 7'd51; ops[1] = 7'd3; ops[2] = 7'd35; ops[3] = 7'd99;
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 3)]};
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [6:0] op;
    logic [31:0] r;
    do op = 7'($urandom_range(0, 127)); while (op inside {7'd51, 7'd3, 7'd35, 7'd99});
    r = $urandom;
    return {r[31:7], op};
  endfunction

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return MT;
    if (r == 1) return MT - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    int cyc;
    rst = 1'b1; instruction = 32'd0; mem_ready = 1'b0; zero = 1'b0;
    m_ret = 0; m_ill = 1'b0; m_to = 1'b0; m_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("init_state", 32'(state), 32'd0);
    chk("init_retired", 32'(retired), 32'd0);

    run_instr(32'h00B50533, 0, 0, 1'b0, cyc);
    chk("rtype_cycles", cyc, 4);
    chk("rtype_retired", 32'(retired), 32'd1);

    run_instr(32'h0002A303, 0, 3, 1'b0, cyc);
    chk("load_cycles", cyc, 8);
    run_instr(32'h0062A023, 0, 0, 1'b0, cyc);
    chk("store_cycles", cyc, 4);
    chk("ldst_retired", 32'(retired), 32'd3);

    run_instr(32'h00B50463, 0, 0, 1'b1, cyc);
    chk("branch_cycles", cyc, 3);
    run_instr(32'h00B50463, 0, 0, 1'b0, cyc);
    chk("branch_retired", 32'(retired), 32'd5);

    // store parked in MEM with the request outstanding, then reset
    instruction = 32'h0062A023;
    step(3'd0, sb(I,O,I,O,I,I,O,2'd0,O,O,O), 1'b1, 1'b0);
    step(3'd1, 12'd0, 1'b0, 1'b0);
    step(3'd2, sb(O,O,O,O,O,O,O,2'd0,I,O,O), 1'b0, 1'b0);
    exp_valid = 1'b0;
    mem_ready = 1'b0;
    #2;
    chk("mid_mem_write", 32'(mem_write), 32'd1);
    do_reset();

    run_instr(32'h00100093, 0, 0, 1'b0, cyc);
    run_halt(20, 1'b1);
    chk("illegal_sticky", 32'(illegal), 32'd1);
    chk("illegal_state", 32'(state), 32'd5);
    do_reset();

    run_instr(32'h00B50533, MT, 0, 1'b0, cyc);
    chk("fetch_to_cycles", cyc, MT);
    run_halt(3, 1'b0);
    chk("fetch_timeout", 32'(timeout), 32'd1);
    do_reset();
    run_instr(32'h00B50533, MT - 1, 0, 1'b0, cyc);
    chk("last_cycle_ready_timeout", 32'(timeout), 32'd0);
    run_instr(32'h0062A023, 0, MT, 1'b0, cyc);
    run_halt(3, 1'b0);
    chk("mem_timeout", 32'(timeout), 32'd1);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      if (m_halt) begin
        run_halt($urandom_range(1, 4), 1'b0);
        do_reset();
      end
      if ($urandom_range(0, 19) == 0)
        run_instr(rand_illegal(), rand_wait(), rand_wait(), rb(), cyc);
      else
        run_instr(rand_legal(), rand_wait(), rand_wait(), rb(), cyc);
    end

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
